riscv_proc_btb_resolve: RTL and testbench

- Resolution and update side of the fetch-stage branch target buffer.
- Holds one record per fetched instruction: pc+4, BTB hit, and predicted target.
- When execute resolves the oldest in-flight instruction, compares the actual outcome with the prediction and emits a BTB write (wen, correct_pc4, correct_target) plus a fetch redirect on mispredict.
- Sits between fetch (record producer) and execute (resolver). Drives the BTB write port and the fetch PC mux.

---
 rtl/riscv_proc_btb_pkg.sv | 24 ++
 rtl/riscv_proc_btb_pred_fifo.sv | 63 ++++++
 rtl/riscv_proc_btb_resolve.sv | 169 ++++++++++++++++
 tb/tb_riscv_proc_btb_resolve.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_proc_btb_pkg.sv
// Shared definitions for the BTB resolution block: FSM state encoding,
// the in-flight prediction record layout and the mispredict helper.
package riscv_proc_btb_pkg;

  // FSM states (legacy-compatible constant encoding)
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  // Record width: pc+4, predicted-taken flag, predicted target
  localparam int PRED_REC_SZ = 32 + 1 + 32;

  typedef struct packed {
    logic [31:0] pc4;
    logic        taken;
    logic [31:0] target;
  } pred_rec_t;

  // A prediction is wrong if direction differs, or both say taken but to different targets
  function automatic logic calc_mispred(input pred_rec_t h, input logic act_taken,
                                        input logic [31:0] act_target);
    return (h.taken != act_taken) | (h.taken & act_taken & (h.target != act_target));
  endfunction

endpackage

// File: rtl/riscv_proc_btb_pred_fifo.sv
// Circular FIFO of in-flight prediction records. Synchronous clear wins
// over push and pop in the same cycle; push when full and pop when empty
// are ignored.
module riscv_proc_btb_pred_fifo #(
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 65,
  parameter int ADDR_SZ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [ADDR_SZ:0] FULL_CNT = (ADDR_SZ+1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_SZ-1:0] r_wptr;
  logic [ADDR_SZ-1:0] r_rptr;
  logic [ADDR_SZ:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == {(ADDR_SZ+1){1'b0}});
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array: written on accepted push only, contents need no reset
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wptr  <= {ADDR_SZ{1'b0}};
      r_rptr  <= {ADDR_SZ{1'b0}};
      r_count <= {(ADDR_SZ+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + ADDR_SZ'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + ADDR_SZ'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (ADDR_SZ+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_SZ+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_proc_btb_resolve.sv
// BTB resolution/update block. Queues one prediction record per fetched
// instruction and, when execute resolves the oldest one, emits a registered
// BTB write and a one-cycle fetch redirect on mispredict.
// Optional macro BTB_RESOLVE_PERF_EN builds the num_br / num_mispred
// performance counters; otherwise those outputs are tied to zero.
module riscv_proc_btb_resolve
  import riscv_proc_btb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_SZ = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_val,
  output logic        pred_rdy,
  input  logic [31:0] pred_pc4,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        res_val,
  input  logic        res_is_br,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        btb_wen,
  output logic [31:0] btb_correct_pc4,
  output logic [31:0] btb_correct_target,
  output logic        redir_val,
  output logic [31:0] redir_pc,
  output logic [31:0] num_br,
  output logic [31:0] num_mispred
);

  logic [0:0]             r_state;
  logic                   r_btb_wen;
  logic [31:0]            r_btb_pc4;
  logic [31:0]            r_btb_target;
  logic                   r_redir_val;
  logic [31:0]            r_redir_pc;

  pred_rec_t              w_wrec;
  pred_rec_t              w_head;
  logic [PRED_REC_SZ-1:0] w_head_bits;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_idle;
  logic                   w_pred_rdy;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic                   w_act_taken;
  logic                   w_mispred;
  logic                   w_upd;
  logic [31:0]            w_correct_pc;

  // Acceptance depends only on registered state (FSM and FIFO occupancy)
  assign w_idle     = (r_state == ST_IDLE);
  assign w_pred_rdy = w_idle & ~w_full;
  assign w_push     = pred_val & w_pred_rdy;
  // Resolutions are dropped while redirecting and when nothing is in flight
  assign w_pop      = res_val & ~w_empty & w_idle;
  // A mispredict squashes every younger record, including one arriving now
  assign w_flush    = w_pop & w_mispred;

  assign w_wrec.pc4    = pred_pc4;
  assign w_wrec.taken  = pred_taken;
  assign w_wrec.target = pred_target;
  assign w_head        = pred_rec_t'(w_head_bits);

  riscv_proc_btb_pred_fifo #(
    .DEPTH   (DEPTH),
    .WIDTH   (PRED_REC_SZ),
    .ADDR_SZ (ADDR_SZ)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_flush),
    .i_push  (w_push),
    .i_wdata (w_wrec),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Compare the head prediction with the actual outcome from execute
  always_comb begin
    w_act_taken = res_is_br & res_taken;
    w_mispred   = calc_mispred(w_head, w_act_taken, res_target);
    w_upd       = w_act_taken & (~w_head.taken | (w_head.target != res_target));
    if (w_act_taken) begin
      w_correct_pc = res_target;
    end else begin
      w_correct_pc = w_head.pc4;
    end
  end

  // Strobes pulse for one cycle; data registers hold until their strobe fires again
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btb_wen    <= 1'b0;
      r_btb_pc4    <= 32'h0;
      r_btb_target <= 32'h0;
      r_redir_val  <= 1'b0;
      r_redir_pc   <= 32'h0;
    end else begin
      r_btb_wen   <= w_pop & w_upd;
      r_redir_val <= w_pop & w_mispred;
      if (w_pop && w_upd) begin
        r_btb_pc4    <= w_head.pc4;
        r_btb_target <= res_target;
      end
      if (w_pop && w_mispred) begin
        r_redir_pc <= w_correct_pc;
      end
    end
  end

  // FSM: a mispredict parks the block for exactly the redirect cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_flush) begin
            r_state <= ST_REDIRECT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REDIRECT: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign pred_rdy           = w_pred_rdy;
  assign btb_wen            = r_btb_wen;
  assign btb_correct_pc4    = r_btb_pc4;
  assign btb_correct_target = r_btb_target;
  assign redir_val          = r_redir_val;
  assign redir_pc           = r_redir_pc;

`ifdef BTB_RESOLVE_PERF_EN
  logic [31:0] r_num_br;
  logic [31:0] r_num_mispred;

  // Performance counters over resolved instructions; wrap at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_br      <= 32'h0;
      r_num_mispred <= 32'h0;
    end else begin
      if (w_pop && res_is_br) begin
        r_num_br <= r_num_br + 32'd1;
      end
      if (w_flush) begin
        r_num_mispred <= r_num_mispred + 32'd1;
      end
    end
  end

  assign num_br      = r_num_br;
  assign num_mispred = r_num_mispred;
`else
  assign num_br      = 32'h0;
  assign num_mispred = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_proc_btb_resolve.sv
// Self-checking bench for riscv_proc_btb_resolve: a reference model drives a
// scoreboard queue of expected register states each cycle, a table of
// single-record scenarios is checked against hand-derived results, and
// hand-written sequences cover flush, full/wrap, reset and empty resolves.
module tb_riscv_proc_btb_resolve;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc4;
    logic        taken;
    logic [31:0] target;
  } rec_t;

  typedef struct {
    logic        wen;
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] nbr;
    logic [31:0] nmis;
  } out_t;

  typedef struct {
    rec_t        p;
    logic        isbr;
    logic        tk;
    logic [31:0] rt;
    logic        ewen;
    logic        eredir;
    logic [31:0] erpc;
    logic [31:0] etgt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, pred_val, pred_rdy, pred_taken;
  logic [31:0] pred_pc4, pred_target;
  logic        res_val, res_is_br, res_taken;
  logic [31:0] res_target;
  logic        btb_wen, redir_val;
  logic [31:0] btb_correct_pc4, btb_correct_target, redir_pc, num_br, num_mispred;

  int   checks = 0;
  int   errors = 0;
  rec_t mq[$];
  out_t exp_q[$];
  out_t m;
  bit   m_redir = 1'b0;
  vec_t tbl[7];
  rec_t z;

  riscv_proc_btb_resolve #(.DEPTH(DEPTH), .ADDR_SZ(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .pred_val           (pred_val),
    .pred_rdy           (pred_rdy),
    .pred_pc4           (pred_pc4),
    .pred_taken         (pred_taken),
    .pred_target        (pred_target),
    .res_val            (res_val),
    .res_is_br          (res_is_br),
    .res_taken          (res_taken),
    .res_target         (res_target),
    .btb_wen            (btb_wen),
    .btb_correct_pc4    (btb_correct_pc4),
    .btb_correct_target (btb_correct_target),
    .redir_val          (redir_val),
    .redir_pc           (redir_pc),
    .num_br             (num_br),
    .num_mispred        (num_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, predict the next register state, then compare after the edge
  task automatic cyc(input logic pv, input rec_t r, input logic rv, input logic isbr,
                     input logic tk, input logic [31:0] rt, input logic rst);
    logic exp_rdy, acc, pop, at, mis, upd, nredir;
    rec_t h;
    out_t nx, e;
    reset = rst; pred_val = pv; pred_pc4 = r.pc4; pred_taken = r.taken;
    pred_target = r.target; res_val = rv; res_is_br = isbr; res_taken = tk; res_target = rt;
    #1;
    exp_rdy = !m_redir && (mq.size() < DEPTH);
    if (!rst) chk("pred_rdy", {31'b0, pred_rdy}, {31'b0, exp_rdy});
    nx = m; nx.wen = 1'b0; nx.redir = 1'b0; nredir = 1'b0;
    if (rst) begin
      nx = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
      mq.delete();
    end else begin
      acc = pv && exp_rdy;
      pop = rv && !m_redir && (mq.size() > 0);
      mis = 1'b0;
      if (pop) begin
        h   = mq.pop_front();
        at  = isbr && tk;
        mis = (h.taken != at) || (h.taken && at && (h.target != rt));
        upd = at && (!h.taken || (h.target != rt));
        nx.wen = upd; nx.redir = mis;
        if (upd) begin nx.pc4 = h.pc4; nx.tgt = rt; end
        if (mis) nx.rpc = at ? rt : h.pc4;
        if (isbr) nx.nbr = nx.nbr + 32'd1;
        if (mis) nx.nmis = nx.nmis + 32'd1;
        nredir = mis;
      end
      if (acc) mq.push_back(r);
      if (pop && mis) mq.delete();
    end
    exp_q.push_back(nx);
    m = nx; m_redir = nredir;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("btb_wen", {31'b0, btb_wen}, {31'b0, e.wen});
    chk("btb_correct_pc4", btb_correct_pc4, e.pc4);
    chk("btb_correct_target", btb_correct_target, e.tgt);
    chk("redir_val", {31'b0, redir_val}, {31'b0, e.redir});
    chk("redir_pc", redir_pc, e.rpc);
`ifdef BTB_RESOLVE_PERF_EN
    chk("num_br", num_br, e.nbr);
    chk("num_mispred", num_mispred, e.nmis);
`else
    chk("num_br", num_br, 32'h0);
    chk("num_mispred", num_mispred, 32'h0);
`endif
  endtask

  task automatic push_rec(input rec_t r);
    cyc(1'b1, r, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic resolve(input logic isbr, input logic tk, input logic [31:0] rt);
    cyc(1'b0, z, 1'b1, isbr, tk, rt, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t r;
    logic [31:0] t;
    z = '{32'h0, 1'b0, 32'h0};
    //            record                         br    tk    res_tgt       wen   redir rpc           tgt
    tbl[0] = '{'{32'h104, 1'b0, 32'h0},   1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0};
    tbl[1] = '{'{32'h204, 1'b0, 32'hDEAD}, 1'b1, 1'b1, 32'h400,  1'b1, 1'b1, 32'h400, 32'h400};
    tbl[2] = '{'{32'h304, 1'b1, 32'h500}, 1'b1, 1'b1, 32'h600,   1'b1, 1'b1, 32'h600, 32'h600};
    tbl[3] = '{'{32'h304, 1'b1, 32'h500}, 1'b1, 1'b1, 32'h500,   1'b0, 1'b0, 32'h0,   32'h0};
    tbl[4] = '{'{32'h404, 1'b1, 32'h800}, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h404, 32'h0};
    tbl[5] = '{'{32'h504, 1'b1, 32'h900}, 1'b0, 1'b1, 32'h123,   1'b0, 1'b1, 32'h504, 32'h0};
    tbl[6] = '{'{32'h604, 1'b0, 32'h0},   1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0,   32'h0};

    // Reset state
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, z, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("reset_pred_rdy", {31'b0, pred_rdy}, 32'h1);

    // Table of single-record scenarios
    for (int i = 0; i < 7; i++) begin
      push_rec(tbl[i].p);
      resolve(tbl[i].isbr, tbl[i].tk, tbl[i].rt);
      chk($sformatf("tbl%0d_wen", i), {31'b0, btb_wen}, {31'b0, tbl[i].ewen});
      chk($sformatf("tbl%0d_redir", i), {31'b0, redir_val}, {31'b0, tbl[i].eredir});
      if (tbl[i].eredir) chk($sformatf("tbl%0d_rpc", i), redir_pc, tbl[i].erpc);
      if (tbl[i].ewen) begin
        chk($sformatf("tbl%0d_pc4", i), btb_correct_pc4, tbl[i].p.pc4);
        chk($sformatf("tbl%0d_tgt", i), btb_correct_target, tbl[i].etgt);
      end
      idle();
    end

    // Flush: mispredict squashes younger records and a same-cycle push
    push_rec('{32'h704, 1'b0, 32'h0});
    push_rec('{32'h708, 1'b0, 32'h0});
    cyc(1'b1, '{32'h70C, 1'b0, 32'h0}, 1'b1, 1'b1, 1'b1, 32'hA00, 1'b0);
    chk("flush_redir_pc", redir_pc, 32'hA00);
    chk("flush_rdy_low", {31'b0, pred_rdy}, 32'h0);
    cyc(1'b1, '{32'h710, 1'b0, 32'h0}, 1'b1, 1'b1, 1'b1, 32'hB00, 1'b0);
    resolve(1'b1, 1'b1, 32'hC00);
    chk("empty_wen", {31'b0, btb_wen}, 32'h0);
    chk("empty_redir", {31'b0, redir_val}, 32'h0);

    // Full and wrap: 8 records pushed in order, each resolved with its own target
    for (int i = 0; i < 4; i++) push_rec('{32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(16 * i)});
    chk("full_rdy", {31'b0, pred_rdy}, 32'h0);
    for (int i = 4; i < 8; i++) begin
      r = '{32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(16 * i)};
      t = mq[0].target;
      cyc(1'b1, r, 1'b1, 1'b1, 1'b1, t, 1'b0);
      if (i == 4) cyc(1'b1, r, 1'b1, 1'b1, 1'b1, mq[0].target, 1'b0);
    end
    chk("wrap_count", mq.size(), 32'd3);
    resolve(1'b1, 1'b1, mq[0].target);
    resolve(1'b1, 1'b1, mq[0].target);
    chk("wrap_no_redir", {31'b0, redir_val}, 32'h0);
    resolve(1'b1, 1'b1, 32'h3000);
    chk("wrap_last_pc4", btb_correct_pc4, 32'h101C);
    chk("wrap_last_wen", {31'b0, btb_wen}, 32'h1);
    idle();

    // Reset between resolve and output drops the pending redirect
    push_rec('{32'h804, 1'b1, 32'hB00});
    cyc(1'b0, z, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_redir", {31'b0, redir_val}, 32'h0);
    chk("rst_redir_pc", redir_pc, 32'h0);
    chk("rst_btb_pc4", btb_correct_pc4, 32'h0);
    resolve(1'b1, 1'b1, 32'hD00);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
